// File: rtl/udiv_seq_if.sv
// ----------------------------------------------------------------------------
// udiv_seq_if -- command/result bundle of the sequential unsigned divider.
//
// Command side : i_vld / o_rdy handshake, i_dividend, i_divisor (W bits).
// Result side  : o_vld / i_rdy handshake, o_quotient, o_remainder (W bits),
//                o_div_by_zero.
// Modports     : slave  -- the divider itself
//                master -- the unit issuing commands and consuming results
// ----------------------------------------------------------------------------
interface udiv_seq_if #(
    parameter int W = 32
);
    logic         i_vld;
    logic         o_rdy;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_vld;
    logic         i_rdy;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    modport slave (
        input  i_vld, i_dividend, i_divisor, i_rdy,
        output o_rdy, o_vld, o_quotient, o_remainder, o_div_by_zero
    );

    modport master (
        output i_vld, i_dividend, i_divisor, i_rdy,
        input  o_rdy, o_vld, o_quotient, o_remainder, o_div_by_zero
    );
endinterface

// File: rtl/udiv_seq.sv
// ----------------------------------------------------------------------------
// udiv_seq -- iterative restoring radix-2 unsigned divider.
//
// Retires one quotient bit per clock using a single W+1-bit subtractor
// (a + ~b + 1). One operation in flight at a time.
//
// Ports:
//   clk  -- clock, all state changes on the rising edge
//   rst  -- synchronous, active-high reset; discards any in-flight operation
//   bus  -- udiv_seq_if.slave: command (i_vld/o_rdy, dividend, divisor) and
//           result (o_vld/i_rdy, quotient, remainder, div_by_zero)
//
// Timing: nonzero divisor -> W BUSY cycles, then DONE. Zero divisor ->
// straight to DONE with quotient all ones and remainder = dividend.
// Results hold in DONE until i_rdy; o_rdy is high only in IDLE.
// ----------------------------------------------------------------------------
module udiv_seq #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst,
    udiv_seq_if.slave  bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [W-1:0]    d_reg;      // latched divisor
    logic [W-1:0]    q_reg;      // dividend shifting out / quotient shifting in
    logic [W-1:0]    r_reg;      // partial remainder
    logic            dbz_reg;
    logic [CW-1:0]   cnt_reg;    // remaining steps minus one

    logic [W:0]      trial;
    logic            div_zero;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor. r_reg[W-1] is dropped: r < d bounds the partial
    // remainder by the dividend prefix consumed so far, so that bit is
    // always zero before a shift. trial[W] set means no borrow (shifted >= d).
    always_comb begin
        div_zero = (bus.i_divisor == '0);
        trial    = {1'b0, r_reg[W-2:0], q_reg[W-1]} + {1'b0, ~d_reg} + (W+1)'(1);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.i_vld) begin
                    state_next = div_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg   <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dbz_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_vld) begin
                        d_reg   <= bus.i_divisor;
                        dbz_reg <= div_zero;
                        cnt_reg <= CW'(W - 1);
                        if (div_zero) begin
                            // Result is final immediately: all-ones quotient,
                            // dividend passed through as remainder.
                            q_reg <= '1;
                            r_reg <= bus.i_dividend;
                        end else begin
                            q_reg <= bus.i_dividend;
                            r_reg <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (trial[W]) begin
                        r_reg <= trial[W-1:0];
                        q_reg <= {q_reg[W-2:0], 1'b1};
                    end else begin
                        r_reg <= {r_reg[W-2:0], q_reg[W-1]};
                        q_reg <= {q_reg[W-2:0], 1'b0};
                    end
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.o_rdy         = (state_reg == IDLE);
    assign bus.o_vld         = (state_reg == DONE);
    assign bus.o_quotient    = q_reg;
    assign bus.o_remainder   = r_reg;
    assign bus.o_div_by_zero = dbz_reg;

endmodule

// File: tb/tb_udiv_seq.sv
// ----------------------------------------------------------------------------
// tb_udiv_seq -- directed self-checking bench for udiv_seq at W=8.
// Inputs are driven and outputs sampled on the falling edge; the divider
// acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_udiv_seq;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    udiv_seq_if #(.W(W)) bus ();

    udiv_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One full transaction: offer, wait for result, optional output stall,
    // consume. While the divider is busy a junk command is kept on the bus
    // to show it is not taken.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_dbz, input int exp_lat, input int stall);
        int lat;
        @(negedge clk);
        check("cmd_rdy", 64'(bus.o_rdy), 64'd1);
        bus.i_vld      = 1'b1;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_rdy      = (stall == 0);
        @(posedge clk);                 // accept edge
        @(negedge clk);
        bus.i_dividend = 8'd77;         // junk command, must be ignored
        bus.i_divisor  = 8'd3;
        lat = 0;
        while (!bus.o_vld && lat < 40) begin
            check("busy_no_rdy", 64'(bus.o_rdy), 64'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        bus.i_vld = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("quotient", 64'(bus.o_quotient), 64'(exp_q));
        check("remainder", 64'(bus.o_remainder), 64'(exp_r));
        check("div_by_zero", 64'(bus.o_div_by_zero), 64'(exp_dbz));
        check("done_no_rdy", 64'(bus.o_rdy), 64'd0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_vld", 64'(bus.o_vld), 64'd1);
            check("stall_rdy", 64'(bus.o_rdy), 64'd0);
            check("stall_q", 64'(bus.o_quotient), 64'(exp_q));
            check("stall_r", 64'(bus.o_remainder), 64'(exp_r));
        end
        bus.i_rdy = 1'b1;
        @(posedge clk);                 // consume edge
        @(negedge clk);
        check("post_vld", 64'(bus.o_vld), 64'd0);
        check("post_rdy", 64'(bus.o_rdy), 64'd1);
        $display("[TB] %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b,
                 bus.o_quotient, bus.o_remainder, bus.o_div_by_zero, lat);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.i_vld      = 1'b0;
        bus.i_rdy      = 1'b1;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_vld", 64'(bus.o_vld), 64'd0);
        check("rst_rdy", 64'(bus.o_rdy), 64'd1);
        check("rst_q", 64'(bus.o_quotient), 64'd0);
        check("rst_r", 64'(bus.o_remainder), 64'd0);
        check("rst_dbz", 64'(bus.o_div_by_zero), 64'd0);

        // nonzero divisor: result after W edges from the accept edge
        run_div(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, W, 0);
        run_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, W, 0);
        run_div(8'd3,   8'd10,  8'd0,   8'd3,   1'b0, W, 0);
        run_div(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, W, 0);
        run_div(8'd0,   8'd5,   8'd0,   8'd0,   1'b0, W, 0);
        run_div(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, W, 0);
        run_div(8'd128, 8'd129, 8'd0,   8'd128, 1'b0, W, 0);
        // zero divisor: DONE straight from the accept edge, so o_vld is
        // already up in the cycle right after the accepting one
        run_div(8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 0, 0);
        run_div(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, W, 0);
        // output stall: result must hold while i_rdy is low
        run_div(8'd200, 8'd9,   8'd22,  8'd2,   1'b0, W, 5);

        // reset during BUSY step 4
        @(negedge clk);
        bus.i_vld      = 1'b1;
        bus.i_dividend = 8'd100;
        bus.i_divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus.i_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_busy_vld", 64'(bus.o_vld), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_vld", 64'(bus.o_vld), 64'd0);
        check("mid_rst_rdy", 64'(bus.o_rdy), 64'd1);
        check("mid_rst_q", 64'(bus.o_quotient), 64'd0);
        check("mid_rst_r", 64'(bus.o_remainder), 64'd0);
        check("mid_rst_dbz", 64'(bus.o_div_by_zero), 64'd0);
        $display("[TB] reset during BUSY -> outputs cleared");
        // full-latency check inside run_div also rules out a stale early result
        run_div(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, W, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
